// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and trap sequencer for the 3-stage RV32I core.
// Generates hold/flush controls, PC redirects and trap CSR strobes from
// ID/EX status and the external interrupt line.
module pipeline_ctrl #(
  parameter logic [3:0] IRQ_CAUSE   = 4'd11,
  parameter logic [3:0] IRQ_HOLDOFF = 4'd2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_reg_src1_addr,
  input  logic [4:0]  i_reg_src2_addr,
  input  logic        i_id_valid,
  input  logic        i_exception_id,
  input  logic [3:0]  i_exception_cause_id,
  input  logic        i_mret_id,
  input  logic [31:0] i_instruction_addr_id,
  input  logic        i_ram_load_access_ex,
  input  logic [4:0]  i_rd_ex,
  input  logic        i_bus_ready,
  input  logic        i_jump_ex,
  input  logic [31:0] i_jump_addr_ex,
  input  logic        i_irq,
  input  logic [31:0] i_mtvec,
  input  logic [31:0] i_mepc,
  output logic        o_hold_pc,
  output logic        o_hold_if_id,
  output logic        o_flush_if_id,
  output logic        o_flush_id_ex,
  output logic        o_pc_wen,
  output logic [31:0] o_pc_wdata,
  output logic        o_trap_wen,
  output logic [31:0] o_trap_mepc,
  output logic [31:0] o_trap_mcause,
  output logic        o_mret_wen
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_MRET = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_holdoff;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        w_capture;
  logic [31:0] w_cap_mepc;
  logic [31:0] w_cap_mcause;

  logic w_bus_stall;
  logic w_exc_take;
  logic w_irq_take;
  logic w_mret_take;
  logic w_load_use;

  assign w_bus_stall = i_ram_load_access_ex && !i_bus_ready;
  assign w_exc_take  = i_id_valid && i_exception_id;
  assign w_irq_take  = i_id_valid && i_irq && (r_holdoff == 4'd0);
  assign w_mret_take = i_id_valid && i_mret_id;
  assign w_load_use  = i_ram_load_access_ex && (i_rd_ex != 5'd0) &&
                       ((i_rd_ex == i_reg_src1_addr) || (i_rd_ex == i_reg_src2_addr));

  // Next-state and combinational pipeline controls; everything forced to 0 in reset.
  always_comb begin
    w_next_state  = r_state;
    w_capture     = 1'b0;
    w_cap_mepc    = 32'd0;
    w_cap_mcause  = 32'd0;
    o_hold_pc     = 1'b0;
    o_hold_if_id  = 1'b0;
    o_flush_if_id = 1'b0;
    o_flush_id_ex = 1'b0;
    o_pc_wen      = 1'b0;
    o_pc_wdata    = 32'd0;
    o_trap_wen    = 1'b0;
    o_trap_mepc   = 32'd0;
    o_trap_mcause = 32'd0;
    o_mret_wen    = 1'b0;
    if (i_rst) begin
      w_next_state = ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_bus_stall) begin
            // EX stays put because ID/EX is not flushed while PC and IF/ID hold.
            o_hold_pc    = 1'b1;
            o_hold_if_id = 1'b1;
          end else if (i_jump_ex) begin
            // ID instruction is wrong-path: its exception/MRET/irq are dropped.
            o_pc_wen      = 1'b1;
            o_pc_wdata    = i_jump_addr_ex;
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
          end else if (w_exc_take) begin
            w_capture     = 1'b1;
            w_cap_mepc    = i_instruction_addr_id;
            w_cap_mcause  = {1'b0, 27'd0, i_exception_cause_id};
            o_hold_pc     = 1'b1;
            o_hold_if_id  = 1'b1;
            o_flush_id_ex = 1'b1;
            w_next_state  = ST_TRAP;
          end else if (w_irq_take) begin
            w_capture     = 1'b1;
            w_cap_mepc    = i_instruction_addr_id;
            w_cap_mcause  = {1'b1, 27'd0, IRQ_CAUSE};
            o_hold_pc     = 1'b1;
            o_hold_if_id  = 1'b1;
            o_flush_id_ex = 1'b1;
            w_next_state  = ST_TRAP;
          end else if (w_mret_take) begin
            o_hold_pc     = 1'b1;
            o_hold_if_id  = 1'b1;
            o_flush_id_ex = 1'b1;
            w_next_state  = ST_MRET;
          end else if (w_load_use) begin
            o_hold_pc     = 1'b1;
            o_hold_if_id  = 1'b1;
            o_flush_id_ex = 1'b1;
          end else begin
            w_next_state = ST_RUN;
          end
        end
        ST_TRAP: begin
          o_trap_wen    = 1'b1;
          o_trap_mepc   = r_mepc;
          o_trap_mcause = r_mcause;
          o_pc_wen      = 1'b1;
          o_pc_wdata    = i_mtvec;
          o_flush_if_id = 1'b1;
          o_flush_id_ex = 1'b1;
          w_next_state  = ST_RUN;
        end
        ST_MRET: begin
          o_mret_wen    = 1'b1;
          o_pc_wen      = 1'b1;
          o_pc_wdata    = i_mepc;
          o_flush_if_id = 1'b1;
          o_flush_id_ex = 1'b1;
          w_next_state  = ST_RUN;
        end
        default: begin
          w_next_state = ST_RUN;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Trap cause/PC capture, updated only when entering TRAP.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mepc   <= 32'd0;
      r_mcause <= 32'd0;
    end else if (w_capture) begin
      r_mepc   <= w_cap_mepc;
      r_mcause <= w_cap_mcause;
    end else begin
      r_mepc   <= r_mepc;
      r_mcause <= r_mcause;
    end
  end

  // Interrupt hold-off: reloaded by TRAP/MRET, counts down to 0 in RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_holdoff <= 4'd0;
    end else begin
      case (r_state)
        ST_RUN:  r_holdoff <= (r_holdoff != 4'd0) ? (r_holdoff - 4'd1) : 4'd0;
        ST_TRAP: r_holdoff <= IRQ_HOLDOFF;
        ST_MRET: r_holdoff <= IRQ_HOLDOFF;
        default: r_holdoff <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios with literal expectations
// plus randomized traffic, all checked each cycle against a behavioural model.
module tb_pipeline_ctrl;

  localparam logic [3:0] P_CAUSE = 4'd11;
  localparam int         P_HOLD  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, exc, mret, load, bus_ready, jump, irq;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  cause;
  logic [31:0] iaddr, jaddr, mtvec, mepc;

  logic        hold_pc, hold_if_id, flush_if_id, flush_id_ex, pc_wen, trap_wen, mret_wen;
  logic [31:0] pc_wdata, trap_mepc, trap_mcause;

  pipeline_ctrl #(.IRQ_CAUSE(P_CAUSE), .IRQ_HOLDOFF(4'd2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_reg_src1_addr(rs1), .i_reg_src2_addr(rs2),
    .i_id_valid(id_valid), .i_exception_id(exc), .i_exception_cause_id(cause),
    .i_mret_id(mret), .i_instruction_addr_id(iaddr),
    .i_ram_load_access_ex(load), .i_rd_ex(rd), .i_bus_ready(bus_ready),
    .i_jump_ex(jump), .i_jump_addr_ex(jaddr), .i_irq(irq),
    .i_mtvec(mtvec), .i_mepc(mepc),
    .o_hold_pc(hold_pc), .o_hold_if_id(hold_if_id),
    .o_flush_if_id(flush_if_id), .o_flush_id_ex(flush_id_ex),
    .o_pc_wen(pc_wen), .o_pc_wdata(pc_wdata),
    .o_trap_wen(trap_wen), .o_trap_mepc(trap_mepc), .o_trap_mcause(trap_mcause),
    .o_mret_wen(mret_wen)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model: pending one-shot actions plus a countdown.
  bit          m_trap_pend, m_mret_pend, x_trap_pend, x_mret_pend;
  int          m_holdoff, x_holdoff;
  logic [31:0] m_mepc, m_mcause, x_mepc, x_mcause;

  logic        e_hold_pc, e_hold_if_id, e_flush_if_id, e_flush_id_ex, e_pc_wen, e_trap_wen, e_mret_wen;
  logic [31:0] e_pc_wdata, e_trap_mepc, e_trap_mcause;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual %h required %h", name, $time, act, exp);
    end
  endtask

  task automatic model_eval();
    e_hold_pc = 1'b0; e_hold_if_id = 1'b0; e_flush_if_id = 1'b0; e_flush_id_ex = 1'b0;
    e_pc_wen = 1'b0; e_pc_wdata = 32'd0; e_trap_wen = 1'b0; e_trap_mepc = 32'd0;
    e_trap_mcause = 32'd0; e_mret_wen = 1'b0;
    x_trap_pend = m_trap_pend; x_mret_pend = m_mret_pend; x_holdoff = m_holdoff;
    x_mepc = m_mepc; x_mcause = m_mcause;
    if (rst) begin
      x_trap_pend = 1'b0;
    end else if (m_trap_pend) begin
      e_trap_wen = 1'b1; e_trap_mepc = m_mepc; e_trap_mcause = m_mcause;
      e_pc_wen = 1'b1; e_pc_wdata = mtvec; e_flush_if_id = 1'b1; e_flush_id_ex = 1'b1;
      x_trap_pend = 1'b0; x_holdoff = P_HOLD;
    end else if (m_mret_pend) begin
      e_mret_wen = 1'b1; e_pc_wen = 1'b1; e_pc_wdata = mepc;
      e_flush_if_id = 1'b1; e_flush_id_ex = 1'b1;
      x_mret_pend = 1'b0; x_holdoff = P_HOLD;
    end else begin
      x_holdoff = (m_holdoff > 0) ? m_holdoff - 1 : 0;
      if (load && !bus_ready) begin
        e_hold_pc = 1'b1; e_hold_if_id = 1'b1;
      end else if (jump) begin
        e_pc_wen = 1'b1; e_pc_wdata = jaddr; e_flush_if_id = 1'b1; e_flush_id_ex = 1'b1;
      end else if (id_valid && exc) begin
        x_mepc = iaddr; x_mcause = 32'(cause); x_trap_pend = 1'b1;
        e_hold_pc = 1'b1; e_hold_if_id = 1'b1; e_flush_id_ex = 1'b1;
      end else if (id_valid && irq && m_holdoff == 0) begin
        x_mepc = iaddr; x_mcause = 32'h8000_0000 + 32'(P_CAUSE); x_trap_pend = 1'b1;
        e_hold_pc = 1'b1; e_hold_if_id = 1'b1; e_flush_id_ex = 1'b1;
      end else if (id_valid && mret) begin
        x_mret_pend = 1'b1;
        e_hold_pc = 1'b1; e_hold_if_id = 1'b1; e_flush_id_ex = 1'b1;
      end else if (load && rd != 5'd0 && (rd == rs1 || rd == rs2)) begin
        e_hold_pc = 1'b1; e_hold_if_id = 1'b1; e_flush_id_ex = 1'b1;
      end
    end
  endtask

  // Settle inputs, then compare every output against the model.
  task automatic settle();
    #1;
    model_eval();
    cmp("hold_pc",     32'(hold_pc),     32'(e_hold_pc));
    cmp("hold_if_id",  32'(hold_if_id),  32'(e_hold_if_id));
    cmp("flush_if_id", 32'(flush_if_id), 32'(e_flush_if_id));
    cmp("flush_id_ex", 32'(flush_id_ex), 32'(e_flush_id_ex));
    cmp("pc_wen",      32'(pc_wen),      32'(e_pc_wen));
    cmp("pc_wdata",    pc_wdata,         e_pc_wdata);
    cmp("trap_wen",    32'(trap_wen),    32'(e_trap_wen));
    cmp("trap_mepc",   trap_mepc,        e_trap_mepc);
    cmp("trap_mcause", trap_mcause,      e_trap_mcause);
    cmp("mret_wen",    32'(mret_wen),    32'(e_mret_wen));
  endtask

  // Advance one clock and commit the model, then return to the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_trap_pend = 1'b0; m_mret_pend = 1'b0; m_holdoff = 0; m_mepc = 32'd0; m_mcause = 32'd0;
    end else begin
      m_trap_pend = x_trap_pend; m_mret_pend = x_mret_pend; m_holdoff = x_holdoff;
      m_mepc = x_mepc; m_mcause = x_mcause;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; id_valid = 1'b0; exc = 1'b0; mret = 1'b0; load = 1'b0; bus_ready = 1'b1;
    jump = 1'b0; irq = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; cause = 4'd0;
    iaddr = 32'd0; jaddr = 32'd0; mtvec = 32'h0000_0800; mepc = 32'd0;
  endtask

  int stall_cnt;

  initial begin
    m_trap_pend = 1'b0; m_mret_pend = 1'b0; m_holdoff = 0; m_mepc = 32'd0; m_mcause = 32'd0;
    idle();
    rst = 1'b1; id_valid = 1'b1; exc = 1'b1; jump = 1'b1; jaddr = 32'h44;
    @(negedge clk);
    settle(); cmp("rst_pc_wen", 32'(pc_wen), 32'd0); cmp("rst_hold_pc", 32'(hold_pc), 32'd0);
    tick(); settle(); tick();

    // Load-use, then no stall when rd_ex is x0.
    idle(); id_valid = 1'b1; load = 1'b1; rd = 5'd5; rs1 = 5'd5;
    settle(); cmp("lu_hold", 32'(hold_pc), 32'd1); cmp("lu_flush", 32'(flush_id_ex), 32'd1); tick();
    idle(); id_valid = 1'b1;
    settle(); cmp("lu_after", 32'(hold_pc), 32'd0); tick();
    idle(); id_valid = 1'b1; load = 1'b1; rd = 5'd0; rs1 = 5'd0;
    settle(); cmp("lu_x0", 32'(flush_id_ex), 32'd0); tick();

    // Bus wait for three cycles with a jump arriving during the wait.
    stall_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      idle(); id_valid = 1'b1; load = 1'b1; rd = 5'd7; rs1 = 5'd1; bus_ready = 1'b0;
      if (i >= 1) begin jump = 1'b1; jaddr = 32'h300; end
      settle();
      if (hold_pc && !flush_id_ex && !pc_wen) stall_cnt++;
      tick();
    end
    cmp("bus_wait_cycles", stall_cnt, 32'd3);
    idle(); id_valid = 1'b1; load = 1'b1; rd = 5'd7; rs1 = 5'd1; jump = 1'b1; jaddr = 32'h300;
    settle(); cmp("bus_jump_wdata", pc_wdata, 32'h300); cmp("bus_jump_hold", 32'(hold_pc), 32'd0); tick();

    // ECALL at 0x100.
    idle(); id_valid = 1'b1; exc = 1'b1; cause = 4'd11; iaddr = 32'h100;
    settle(); cmp("ecall_trapwen_early", 32'(trap_wen), 32'd0); tick();
    idle();
    settle();
    cmp("ecall_trap_wen", 32'(trap_wen), 32'd1); cmp("ecall_mepc", trap_mepc, 32'h100);
    cmp("ecall_mcause", trap_mcause, 32'h0000_000B); cmp("ecall_pc", pc_wdata, 32'h800);
    cmp("ecall_flush_if", 32'(flush_if_id), 32'd1); cmp("ecall_flush_ex", 32'(flush_id_ex), 32'd1);
    tick();

    // Interrupt: ignored during the two hold-off cycles, then taken.
    for (int i = 0; i < 3; i++) begin
      idle(); id_valid = 1'b1; irq = 1'b1; iaddr = 32'h204;
      settle(); cmp("irq_gate", 32'(hold_pc), (i == 2) ? 32'd1 : 32'd0); tick();
    end
    idle(); irq = 1'b1;
    settle(); cmp("irq_mcause", trap_mcause, 32'h8000_000B); cmp("irq_mepc", trap_mepc, 32'h204); tick();
    idle(); id_valid = 1'b1; mret = 1'b1; irq = 1'b1;
    settle(); cmp("mret_detect", 32'(hold_pc), 32'd1); tick();
    idle(); irq = 1'b1; mepc = 32'h204;
    settle(); cmp("mret_wen", 32'(mret_wen), 32'd1); cmp("mret_pc", pc_wdata, 32'h204); tick();
    for (int i = 0; i < 3; i++) begin
      idle(); id_valid = 1'b1; irq = 1'b1; iaddr = 32'h300;
      settle(); cmp("irq_gate2", 32'(hold_pc), (i == 2) ? 32'd1 : 32'd0); tick();
    end
    idle(); settle(); tick();
    for (int i = 0; i < 3; i++) begin idle(); settle(); tick(); end

    // Jump against exception: jump wins, no trap ever.
    idle(); id_valid = 1'b1; exc = 1'b1; cause = 4'd2; jump = 1'b1; jaddr = 32'h40;
    settle(); cmp("jx_pc", pc_wdata, 32'h40); cmp("jx_wen", 32'(pc_wen), 32'd1); tick();
    idle(); settle(); cmp("jx_no_trap", 32'(trap_wen), 32'd0); tick();

    // Jump together with a load-use match: no bubble hold.
    idle(); id_valid = 1'b1; load = 1'b1; rd = 5'd5; rs2 = 5'd5; jump = 1'b1; jaddr = 32'h80;
    settle(); cmp("jlu_hold", 32'(hold_pc), 32'd0); cmp("jlu_pc", pc_wdata, 32'h80); tick();

    // Exception and irq together: the exception cause is recorded.
    idle(); id_valid = 1'b1; exc = 1'b1; cause = 4'd2; irq = 1'b1; iaddr = 32'h600;
    settle(); tick();
    idle(); settle(); cmp("excirq_mcause", trap_mcause, 32'h2); tick();
    for (int i = 0; i < 3; i++) begin idle(); settle(); tick(); end

    // Reset in the TRAP cycle.
    idle(); id_valid = 1'b1; exc = 1'b1; cause = 4'd3; iaddr = 32'h500;
    settle(); tick();
    idle(); rst = 1'b1;
    settle(); cmp("rst_trap_wen", 32'(trap_wen), 32'd0); cmp("rst_trap_pc", 32'(pc_wen), 32'd0); tick();
    idle(); settle(); cmp("post_rst_trap", 32'(trap_wen), 32'd0); tick();
    idle(); settle(); tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      id_valid  = ($urandom_range(0, 9) < 8);
      exc       = ($urandom_range(0, 9) == 0);
      cause     = 4'($urandom);
      mret      = ($urandom_range(0, 11) == 0);
      irq       = ($urandom_range(0, 9) < 3);
      load      = ($urandom_range(0, 9) < 3);
      bus_ready = ($urandom_range(0, 9) < 7);
      jump      = ($urandom_range(0, 19) < 3);
      rd        = 5'($urandom_range(0, 3));
      rs1       = 5'($urandom_range(0, 3));
      rs2       = 5'($urandom_range(0, 3));
      iaddr     = $urandom & 32'hFFFF_FFFC;
      jaddr     = $urandom & 32'hFFFF_FFFC;
      mtvec     = $urandom & 32'hFFFF_FFFC;
      mepc      = $urandom & 32'hFFFF_FFFC;
      settle();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
